// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Package  : lsu_pkg
// Brief    : Shared types and lane-width constants for the load/store unit.
// Revision : 1.0
// ============================================================================
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        RMW_RD = 3'd2,
        STORE  = 3'd3,
        RESP   = 3'd4
    } state_e;

    localparam int c_byte_w = 8;
    localparam int c_half_w = 16;
    localparam int c_word_w = 32;

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module   : lsu_align
// Brief    : Lane extract/extend for loads and byte/half merge for stores.
// Revision : 1.0
// ============================================================================
module lsu_align
    import lsu_pkg::*;
(
    input  logic [c_word_w-1:0] i_word,
    input  logic [1:0]          i_lane,
    input  logic [1:0]          i_size,
    input  logic                i_unsigned,
    input  logic [c_word_w-1:0] i_wdata,
    output logic [c_word_w-1:0] o_load,
    output logic [c_word_w-1:0] o_merge
);

    logic [4:0]          w_shamt;
    logic [c_word_w-1:0] w_shifted;
    logic [c_word_w-1:0] w_mask;
    logic [c_byte_w-1:0] w_byte;
    logic [c_half_w-1:0] w_half;

    // Halves are 2-byte aligned, so the byte-lane shift also serves halfwords.
    assign w_shamt   = {i_lane, 3'b000};
    assign w_shifted = i_word >> w_shamt;
    assign w_byte    = w_shifted[c_byte_w-1:0];
    assign w_half    = w_shifted[c_half_w-1:0];

    always_comb begin
        o_load = w_shifted;
        w_mask = '1;
        case (i_size)
            SZ_BYTE: begin
                o_load = {{(c_word_w-c_byte_w){~i_unsigned & w_byte[c_byte_w-1]}}, w_byte};
                w_mask = 32'h0000_00FF << w_shamt;
            end
            SZ_HALF: begin
                o_load = {{(c_word_w-c_half_w){~i_unsigned & w_half[c_half_w-1]}}, w_half};
                w_mask = 32'h0000_FFFF << w_shamt;
            end
            default: ;
        endcase
    end

    assign o_merge = (i_word & ~w_mask) | ((i_wdata << w_shamt) & w_mask);

endmodule
`default_nettype wire

// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
// Module   : lsu
// Brief    : Load/store unit with range/alignment check and RMW sub-word stores.
// Revision : 1.0
// ============================================================================
module lsu
    import lsu_pkg::*;
#(
    parameter logic [31:0] DMEM_BASE_ADDR = 32'h1000,
    parameter int          DMEM_WORDS     = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        memr,
    output logic        memw,
    input  logic [31:0] mem_rdata
);

    localparam logic [32:0] c_dmem_end = 33'(DMEM_BASE_ADDR) + 33'(DMEM_WORDS) * 33'd4;

    state_e      r_state;
    logic [31:0] r_addr;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic        r_we;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic [31:0] r_merge;
    logic        r_err;

    logic        w_misaligned;
    logic        w_range_ok;
    logic        w_err;
    logic [31:0] w_align_word;
    logic [31:0] w_load;
    logic [31:0] w_merge;

    always_comb begin
        w_misaligned = 1'b0;
        case (req_size)
            SZ_HALF: w_misaligned = req_addr[0];
            SZ_WORD: w_misaligned = |req_addr[1:0];
            default: ;
        endcase
    end

    // 33-bit compare so a memory ending at 4 GiB does not wrap.
    assign w_range_ok = (req_addr >= DMEM_BASE_ADDR) && ({1'b0, req_addr} < c_dmem_end);
    assign w_err      = w_misaligned || !w_range_ok || (req_size == 2'b11);

    assign w_align_word = (r_state == STORE) ? r_merge : mem_rdata;

    lsu_align u_align (
        .i_word     (w_align_word),
        .i_lane     (r_addr[1:0]),
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .i_wdata    (r_wdata),
        .o_load     (w_load),
        .o_merge    (w_merge)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_size     <= '0;
            r_unsigned <= 1'b0;
            r_we       <= 1'b0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_merge    <= '0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_addr     <= req_addr;
                        r_size     <= req_size;
                        r_unsigned <= req_unsigned;
                        r_we       <= req_we;
                        r_wdata    <= req_wdata;
                        r_rdata    <= '0;
                        r_merge    <= '0;
                        r_err      <= w_err;
                        if (w_err)
                            r_state <= RESP;
                        else if (!req_we)
                            r_state <= LOAD;
                        else if (req_size == SZ_WORD)
                            r_state <= STORE;
                        else
                            r_state <= RMW_RD;
                    end
                end
                LOAD: begin
                    r_rdata <= w_load;
                    r_state <= RESP;
                end
                RMW_RD: begin
                    r_merge <= mem_rdata;
                    r_state <= STORE;
                end
                STORE:   r_state <= RESP;
                RESP:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready  = (r_state == IDLE);
    assign resp_valid = (r_state == RESP);
    assign resp_err   = resp_valid & r_err;
    assign resp_rdata = (resp_valid && !r_we) ? r_rdata : '0;
    assign memr       = (r_state == LOAD) || (r_state == RMW_RD);
    assign memw       = (r_state == STORE);
    assign mem_addr   = {r_addr[31:2], 2'b00};
    assign mem_wdata  = (r_state != STORE) ? '0 :
                        (r_size == SZ_WORD) ? r_wdata : w_merge;

endmodule
`default_nettype wire

// File: tb/tb_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu
// Brief    : Scoreboard bench for lsu with a behavioural word memory.
// Revision : 1.0
// ============================================================================
module tb_lsu;

    localparam logic [31:0] c_base = 32'h1000;
    localparam logic [31:0] c_end  = 32'h2000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        memr;
    logic        memw;
    logic [31:0] mem_rdata;

    lsu dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .memr         (memr),
        .memw         (memw),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    logic [31:0] mem     [0:1023];
    logic [31:0] ref_mem [0:1023];
    logic [31:0] w_off;
    logic        w_inr;

    assign w_off     = mem_addr - c_base;
    assign w_inr     = (mem_addr >= c_base) && (mem_addr < c_end);
    assign mem_rdata = w_inr ? mem[w_off[11:2]] : 32'h0;

    always @(posedge clk)
        if (memw && w_inr) mem[w_off[11:2]] <= mem_wdata;

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
        int          nr;
        int          nw;
        logic [31:0] addr;
        logic        st;
        logic [1:0]  size;
        logic [31:0] wdata;
    } exp_t;

    exp_t sb[$];
    int cyc = 0;
    int memr_n = 0, memw_n = 0, overlap = 0, resp_cnt = 0;
    int last_acc = 0, last_resp = 0;
    logic [31:0] strobe_addr = '0;

    function automatic logic [31:0] model_load(input logic [31:0] word, input logic [1:0] lane,
                                               input logic [1:0] size, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[8*lane +: 8];
        h = word[16*lane[1] +: 16];
        if (size == 2'b00) return uns ? {24'h0, b} : {{24{b[7]}}, b};
        if (size == 2'b01) return uns ? {16'h0, h} : {{16{h[15]}}, h};
        return word;
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] word, input logic [1:0] lane,
                                                input logic [1:0] size, input logic [31:0] wd);
        logic [31:0] r;
        r = word;
        if (size == 2'b00)      r[8*lane +: 8] = wd[7:0];
        else if (size == 2'b01) r[16*lane[1] +: 16] = wd[15:0];
        else                    r = wd;
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset) begin
            sb.delete();
            memr_n = 0;
            memw_n = 0;
        end else begin
            if (memr && memw) overlap++;
            if (memr) begin memr_n++; strobe_addr = mem_addr; end
            if (memw) begin memw_n++; strobe_addr = mem_addr; end
            if (resp_valid) begin
                if (sb.size() == 0) begin
                    check("spurious_resp", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    resp_cnt++;
                    last_resp = cyc;
                    check("rdata", resp_rdata, e.rdata);
                    check("err", {31'h0, resp_err}, {31'h0, e.err});
                    check("latency", cyc, e.due);
                    check("memr_cycles", memr_n, e.nr);
                    check("memw_cycles", memw_n, e.nw);
                    if (!e.err)
                        check("mem_addr", strobe_addr, e.addr & ~32'h3);
                    if (e.st && !e.err)
                        ref_mem[(e.addr - c_base) >> 2] =
                            model_store(ref_mem[(e.addr - c_base) >> 2], e.addr[1:0], e.size, e.wdata);
                end
            end
            if (req_valid && req_ready) begin
                exp_t e;
                logic [31:0] a;
                a = req_addr;
                e.err = (req_size == 2'b11) || (req_size == 2'b01 && a[0]) ||
                        (req_size == 2'b10 && a[1:0] != 2'b00) || a < c_base || a >= c_end;
                e.st    = req_we;
                e.size  = req_size;
                e.wdata = req_wdata;
                e.addr  = a;
                e.rdata = (e.err || req_we) ? 32'h0 :
                          model_load(ref_mem[(a - c_base) >> 2], a[1:0], req_size, req_unsigned);
                e.due   = cyc + (e.err ? 1 : (req_we && req_size != 2'b10) ? 3 : 2);
                e.nr    = e.err ? 0 : (!req_we || req_size != 2'b10) ? 1 : 0;
                e.nw    = (!e.err && req_we) ? 1 : 0;
                memr_n  = 0;
                memw_n  = 0;
                last_acc = cyc;
                sb.push_back(e);
            end
        end
    end

    int expect_resp = 0;

    task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd);
        logic ok;
        ok = 1'b0;
        req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1'b1; break; end
        end
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
        expect_resp++;
        @(posedge clk); #1;
    endtask

    task automatic wait_done();
        logic ok;
        ok = 1'b0;
        req_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            if (sb.size() == 0) begin ok = 1'b1; break; end
        end
        if (!ok) check("resp_timeout", 32'd0, 32'd1);
        #1;
    endtask

    task automatic op(input logic we, input logic [1:0] sz, input logic uns,
                      input logic [31:0] a, input logic [31:0] wd);
        issue(we, sz, uns, a, wd);
        wait_done();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i] = 32'h0;
            ref_mem[i] = 32'h0;
        end
        mem[0] = 32'h8070F004;
        ref_mem[0] = 32'h8070F004;

        repeat (3) @(negedge clk);
        check("rst_ready", {31'h0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'h0, resp_valid}, 32'd0);
        check("rst_resp_err", {31'h0, resp_err}, 32'd0);
        check("rst_rdata", resp_rdata, 32'h0);
        check("rst_strobes", {30'h0, memr, memw}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        op(1'b0, 2'b10, 1'b0, 32'h1000, 32'h0);
        op(1'b0, 2'b00, 1'b0, 32'h1003, 32'h0);
        op(1'b0, 2'b00, 1'b1, 32'h1003, 32'h0);
        op(1'b0, 2'b01, 1'b0, 32'h1002, 32'h0);
        op(1'b0, 2'b01, 1'b1, 32'h1000, 32'h0);
        op(1'b0, 2'b00, 1'b0, 32'h1001, 32'h0);

        op(1'b1, 2'b00, 1'b0, 32'h1001, 32'h000000AA);
        op(1'b0, 2'b10, 1'b0, 32'h1000, 32'h0);
        check("sb_mem_word", mem[0], 32'h8070AA04);

        op(1'b0, 2'b10, 1'b0, 32'h1002, 32'h0);
        op(1'b1, 2'b10, 1'b0, 32'h0FFC, 32'h12345678);
        op(1'b1, 2'b10, 1'b0, 32'h2000, 32'h12345678);
        op(1'b0, 2'b11, 1'b0, 32'h1000, 32'h0);
        op(1'b1, 2'b01, 1'b0, 32'h1003, 32'h0000BEEF);
        op(1'b1, 2'b10, 1'b0, 32'h1FFC, 32'hCAFE1234);
        op(1'b0, 2'b01, 1'b0, 32'h1FFE, 32'h0);
        op(1'b1, 2'b01, 1'b0, 32'h1006, 32'h00009ABC);
        op(1'b0, 2'b10, 1'b0, 32'h1004, 32'h0);

        // Reset pulled low while the sub-word store sits in its read phase.
        issue(1'b1, 2'b01, 1'b0, 32'h1000, 32'h00005555);
        expect_resp--;
        req_valid = 1'b0;
        #2;
        check("rmw_rd_memr", {31'h0, memr}, 32'd1);
        reset = 1'b0;
        #1;
        check("abort_memr", {31'h0, memr}, 32'd0);
        check("abort_ready", {31'h0, req_ready}, 32'd1);
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_ready", {31'h0, req_ready}, 32'd1);
        check("abort_mem_word", mem[0], 32'h8070AA04);
        @(posedge clk); #1;
        op(1'b0, 2'b10, 1'b0, 32'h1000, 32'h0);

        issue(1'b0, 2'b10, 1'b0, 32'h1000, 32'h0);
        issue(1'b0, 2'b01, 1'b1, 32'h1002, 32'h0);
        check("b2b_load_gap", last_acc - last_resp, 32'd1);
        issue(1'b1, 2'b00, 1'b0, 32'h1000, 32'h00000011);
        check("b2b_store_gap", last_acc - last_resp, 32'd1);
        issue(1'b0, 2'b00, 1'b1, 32'h1000, 32'h0);
        check("b2b_rmw_gap", last_acc - last_resp, 32'd1);
        wait_done();
        check("b2b_mem_word", mem[0], 32'h8070AA11);

        repeat (3) @(posedge clk);
        check("overlap", overlap, 32'd0);
        check("resp_count", resp_cnt, expect_resp);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/lsu.md
# lsu

Load/store unit sitting between the core's memory stage and the word-organised data memory. Accepts one load or store request at a time, checks alignment and address range, issues word-wide `memr`/`memw` accesses on the data-memory port, and returns a sign- or zero-extended load result. Byte and halfword stores run as read-modify-write, because the memory only writes full words.

## Interface
- `DMEM_BASE_ADDR`, default 32'h1000: first byte address of data memory.
- `DMEM_WORDS`, default 1024: memory depth in 32-bit words. The valid range is `[DMEM_BASE_ADDR, DMEM_BASE_ADDR + 4*DMEM_WORDS)`.

Ports:
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `req_valid` input 1: request present.
- `req_ready` output 1: unit can accept. High only in IDLE.
- `req_we` input 1: 1 = store, 0 = load.
- `req_size` input 2: 00 = byte, 01 = half, 10 = word, 11 = illegal (flagged as error).
- `req_unsigned` input 1: zero-extend loads.
- `req_addr` input 32: byte address.
- `req_wdata` input 32: store data, LSB-aligned.
- `resp_valid` output 1: one-cycle completion pulse. There is no backpressure.
- `resp_rdata` output 32: load result; 0 for stores and errors.
- `resp_err` output 1: misaligned, out-of-range or illegal-size request.
- `mem_addr` output 32: word-aligned byte address (`req_addr & ~3`).
- `mem_wdata` output 32: write word.
- `memr` output 1: memory read strobe.
- `memw` output 1: memory write strobe.
- `mem_rdata` input 32: combinational read data from memory.

## Operation
- **Accept:** in IDLE with `req_valid=1` the request is accepted. Address, size, unsigned, we and wdata are latched, and `req_ready` drops the next cycle.
- **Error check at accept:**
  - half needs `addr[0]=0`; word needs `addr[1:0]=0`;
  - the address must be in range;
  - size must not be 11.
  - On failure go to RESP with `err=1`. No memory strobe is ever raised.
- **States:**
  - IDLE → LOAD (load), STORE (word store), RMW_RD (byte/half store), or RESP (error).
  - LOAD: `memr=1`. Extracted result registered at the edge. → RESP.
  - RMW_RD: `memr=1`. `mem_rdata` captured into the merge register. → STORE.
  - STORE: `memw=1`. `mem_wdata` is the full wdata (word) or the merged word. → RESP.
  - RESP: `resp_valid=1` → IDLE.
- **Lane rules:**
  - Byte lane = `addr[1:0]`; half lane = `addr[1]`.
  - Load: shift right by `lane*8` or `lane*16`, then sign-extend bit 7/15 unless `req_unsigned`.
  - Store merge: replace only the addressed byte/half with `wdata[7:0]` / `wdata[15:0]`; all other bits come from the captured word.
- `memr` and `memw` are never high together, and each is high for exactly one cycle per access.

## Timing
- Accept edge = T.
  - Word load: LOAD at T+1, `resp_valid` at T+2.
  - Word store: `resp_valid` at T+2.
  - Byte/half store: `resp_valid` at T+3.
  - Error: `resp_valid` at T+1.
- `req_ready=1` again in the cycle after RESP. Back-to-back throughput is one request per 3/3/4/2 cycles respectively.
- All outputs are decoded from state plus registers, with no combinational path from `req_*`.
- **Reset values:** state IDLE, all registers 0, `req_ready=1`, `resp_valid=0`, `resp_err=0`, `resp_rdata=0`, `memr=0`, `memw=0`, `mem_addr=0`, `mem_wdata=0`.
- **Reset asserted mid-operation:**
  - Takes effect immediately: strobes drop asynchronously and the pending response is discarded.
  - A store aborted in RMW_RD or STORE before its edge leaves memory unchanged.
- Requests are not accepted while `reset` is low.

## Structure
- Package `lsu_pkg`:
  - `size_e` enum (`SZ_BYTE`, `SZ_HALF`, `SZ_WORD`);
  - `state_e` (`IDLE`, `LOAD`, `RMW_RD`, `STORE`, `RESP`);
  - lane-width constants.
- One combinational sub-module, `lsu_align`: load extract/extend and store merge, given word, lane, size and unsigned.
- The FSM and range/alignment check live in `lsu`.

## Test plan
The bench instantiates the data memory with word at 0x1000 = 32'h8070F004.

1. Release reset, lw 0x1000 → `memr` one cycle at T+1, `resp_valid` at T+2, rdata 32'h8070F004, err 0.
2. Loads from the same word:
   - lb 0x1003 → 32'hFFFFFF80;
   - lbu 0x1003 → 32'h00000080;
   - lh 0x1002 → 32'hFFFF8070;
   - lhu 0x1000 → 32'h0000F004.
3. sb 0x1001 wdata 32'h000000AA → `memr` at T+1, `memw` at T+2 with 32'h8070AA04, resp at T+3. A following lw reads 32'h8070AA04.
4. Error cases, each giving `resp_err=1` at T+1 with `memr`/`memw` never asserted:
   - lw 0x1002 (misaligned);
   - sw 0x0FFC and sw 0x2000 (out of range);
   - size 11.
5. Reset low during RMW_RD of sh 0x1000 → no `memw`, memory unchanged, `req_ready=1` after release.
6. `req_valid` held high with a queued second request → second accepted only the cycle after RESP; exactly one `resp_valid` per request.
